alu_ctrl: RTL and testbench

Sequencer that owns the start/done handshake to the ALU's arithmetic units (add, sub, mul, div). It accepts one operation request at a time and captures the operands. It pulses exactly one unit's start, waits for that unit's done, and then returns the registered 16-bit signed result with a one-cycle valid strobe. It sits between the top-level command interface and the per-operation units, so that upstream logic never handles unit timing.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_ctrl_watchdog.sv | 36 +++
 rtl/alu_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, opcode numbering and datapath widths for the ALU
// controller and its arithmetic units.
package alu_pkg;

    localparam int RESULT_W  = 16;
    localparam int OPERAND_W = 8;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_watchdog.sv
// alu_ctrl_watchdog: counts WAIT cycles and flags expiry on the TIMEOUT-th cycle
// without a done. Only instantiated when ALU_CTRL_TIMEOUT_EN is defined.
module alu_ctrl_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of WAIT cycles already completed before this one.
    assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: one-request-at-a-time sequencer owning the start/done handshake to the
// arithmetic units. Define ALU_CTRL_TIMEOUT_EN to compile in the WAIT watchdog.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int OP_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
    input  logic [OP_W-1:0]                   op,
    input  logic signed [OPERAND_W-1:0]       a,
    input  logic signed [OPERAND_W-1:0]       b,
    output logic                              busy,
    output logic                              valid,
    output logic                              error,
    output logic signed [RESULT_W-1:0]        result,
    output logic signed [OPERAND_W-1:0]       unit_a,
    output logic signed [OPERAND_W-1:0]       unit_b,
    output logic [NUM_UNITS-1:0]              unit_start,
    input  logic [NUM_UNITS-1:0]              unit_done,
    input  logic [RESULT_W*NUM_UNITS-1:0]     unit_result
);

    state_e                      state_q, state_d;
    logic [OP_W-1:0]             op_q, op_d;
    logic signed [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
    logic [NUM_UNITS-1:0]        start_q, start_d;
    logic                        valid_q, valid_d;
    logic                        error_q, error_d;
    logic signed [RESULT_W-1:0]  result_q, result_d;

    logic                        op_legal;
    logic                        done_sel;
    logic signed [RESULT_W-1:0]  res_sel;
    logic                        expired;

    assign op_legal = (32'(op) < NUM_UNITS);

    // Only the latched unit's done and result slice are ever looked at.
    always_comb begin
        done_sel = 1'b0;
        res_sel  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (op_q == OP_W'(k)) begin
                done_sel = unit_done[k];
                res_sel  = unit_result[k*RESULT_W +: RESULT_W];
            end
        end
    end

`ifdef ALU_CTRL_TIMEOUT_EN
    alu_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ST_ISSUE),
        .en      (state_q == ST_WAIT),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        start_d  = '0;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (op_legal) begin
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        start_d = NUM_UNITS'(1) << op;
                        state_d = ST_ISSUE;
                    end else begin
                        valid_d  = 1'b1;
                        error_d  = 1'b1;
                        result_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle takes priority over the abort.
                if (done_sel) begin
                    result_d = res_sel;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired) begin
                    result_d = '0;
                    valid_d  = 1'b1;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign valid      = valid_q;
    assign error      = error_q;
    assign result     = result_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_start = start_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: drives alu_ctrl (3 units: add, sub, mul) with a vector table, hand-written
// corner sequences and random traffic checked against an arithmetic reference model.
module tb_alu_ctrl;

    localparam int NU  = 3;
    localparam int OPW = 2;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                go;
    logic [OPW-1:0]      op;
    logic signed [7:0]   a, b;
    logic                busy, valid, error;
    logic signed [15:0]  result;
    logic signed [7:0]   unit_a, unit_b;
    logic [NU-1:0]       unit_start, unit_done;
    logic [16*NU-1:0]    unit_result;

    always #5 clk = ~clk;

    alu_ctrl #(
        .NUM_UNITS (NU),
        .OP_W      (OPW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid       (valid),
        .error       (error),
        .result      (result),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .unit_result (unit_result)
    );

    // Unit models: capture operands on start, raise done for one cycle dly[k] edges later.
    int unsigned       dly [NU] = '{1, 2, 3};
    int unsigned       cnt [NU] = '{default: 0};
    logic [NU-1:0]     done_r = '0;
    logic [NU-1:0]     mute = '0;
    logic [NU-1:0]     noise_man = '0;
    logic [NU-1:0]     noise_rnd = '0;
    logic [NU-1:0]     nmask = '0;
    logic              noise_en = 1'b0;
    logic signed [7:0] ua [NU] = '{default: 0};
    logic signed [7:0] ub [NU] = '{default: 0};
    logic signed [7:0] s0, s1;
    logic signed [15:0] p2;

    always @(posedge clk) begin
        for (int k = 0; k < NU; k++) begin
            done_r[k] <= 1'b0;
            if (unit_start[k] === 1'b1) begin
                cnt[k] <= dly[k];
                ua[k]  <= unit_a;
                ub[k]  <= unit_b;
            end else if (cnt[k] != 0) begin
                cnt[k] <= cnt[k] - 1;
                if (cnt[k] == 1) done_r[k] <= 1'b1;
            end
        end
    end

    always_comb begin
        s0 = ua[0] + ub[0];
        s1 = ua[1] - ub[1];
        p2 = ua[2] * ub[2];
        unit_result = {p2, {{8{s1[7]}}, s1}, {{8{s0[7]}}, s0}};
    end

    assign unit_done = (done_r & ~mute) | noise_man | noise_rnd;

    // Spurious done pulses from units other than the one in flight.
    always @(negedge clk) begin
        if (noise_en) noise_rnd = 3'($urandom) & ~nmask;
        else          noise_rnd = '0;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected ALU behaviour: add/sub wrap to 8-bit signed then sign-extend, mul is full 16-bit.
    function automatic logic signed [15:0] ref_result(input int o, input int x, input int y);
        int r;
        case (o)
            0: r = x + y;
            1: r = x - y;
            2: return 16'(x * y);
            default: return 16'sd0;
        endcase
        r = ((r + 128) % 256 + 256) % 256 - 128;
        return 16'(r);
    endfunction

    // lat = edges after the go-sampling edge until valid is seen (illegal op: 0).
    task automatic wait_valid(input int budget, output int lat, output int nstart,
                              output logic [NU-1:0] svec, output logic hung);
        lat = 0; nstart = 0; svec = '0; hung = 1'b0;
        while (valid !== 1'b1) begin
            if (unit_start != '0) begin
                nstart++;
                svec |= unit_start;
            end
            if (lat >= budget) begin
                hung = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input int o, input int x, input int y, input int budget,
                         output logic signed [15:0] r, output logic e, output int lat,
                         output int nstart, output logic [NU-1:0] svec, output logic hung);
        nmask = (o < NU) ? NU'(1) << o : '0;
        go = 1'b1; op = OPW'(o); a = 8'(x); b = 8'(y);
        @(posedge clk); #1;
        go = 1'b0;
        wait_valid(budget, lat, nstart, svec, hung);
        r = result;
        e = error;
    endtask

    typedef struct {
        string             name;
        int                o;
        int                x;
        int                y;
        logic signed [15:0] res;
        logic              err;
        int                lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic signed [15:0] r;
        logic               e, hung;
        int                 lat, nstart, vcount;
        logic [NU-1:0]      svec;
        int                 o, x, y;

        vecs[0] = '{"add",      0,    5,    3, 16'sd8,      1'b0, 3};
        vecs[1] = '{"add_wrap", 0, -128,   -1, 16'sh007F,   1'b0, 3};
        vecs[2] = '{"add_ovf",  0,  127,    1, 16'shFF80,   1'b0, 3};
        vecs[3] = '{"sub",      1,   10,   20, 16'shFFF6,   1'b0, 4};
        vecs[4] = '{"sub_wrap", 1, -128,    1, 16'sh007F,   1'b0, 4};
        vecs[5] = '{"mul",      2,   -7,    9, 16'shFFC1,   1'b0, 5};
        vecs[6] = '{"mul_max",  2,  127, -128, 16'shC080,   1'b0, 5};
        vecs[7] = '{"illegal",  3,    1,    1, 16'sd0,      1'b1, 0};

        rst = 1'b1; go = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_start", unit_start, 0);
        chk("rst_unit_a", unit_a, 0);
        chk("rst_unit_b", unit_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].o, vecs[i].x, vecs[i].y, 50, r, e, lat, nstart, svec, hung);
            chk({vecs[i].name, "_hung"}, hung, 0);
            chk({vecs[i].name, "_result"}, r, vecs[i].res);
            chk({vecs[i].name, "_error"}, e, vecs[i].err);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_nstart"}, nstart, vecs[i].err ? 0 : 1);
            chk({vecs[i].name, "_svec"}, svec, vecs[i].err ? 0 : (1 << vecs[i].o));
            chk({vecs[i].name, "_busy_at_valid"}, busy, 0);
            @(posedge clk); #1;
            chk({vecs[i].name, "_valid_drop"}, valid, 0);
            chk({vecs[i].name, "_result_hold"}, result, vecs[i].res);
        end

        // go during WAIT is ignored; go in the valid cycle starts the next op.
        nmask = 3'b100;
        go = 1'b1; op = 2'd2; a = 8'sd3; b = 8'sd4;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #1;
        go = 1'b1; op = 2'd0; a = 8'sd100; b = -8'sd50;
        @(posedge clk); #1;
        go = 1'b0;
        chk("busy_go_unit_a", unit_a, 3);
        chk("busy_go_unit_b", unit_b, 4);
        chk("busy_go_busy", busy, 1);
        chk("busy_go_start", unit_start, 0);
        wait_valid(20, lat, nstart, svec, hung);
        chk("busy_go_hung", hung, 0);
        chk("busy_go_result", result, 12);
        chk("busy_go_error", error, 0);
        chk("busy_go_lat", lat, 3);
        nmask = 3'b001;
        go = 1'b1; op = 2'd0; a = 8'sd20; b = 8'sd22;
        @(posedge clk); #1;
        go = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_start", unit_start, 3'b001);
        chk("b2b_unit_a", unit_a, 20);
        wait_valid(20, lat, nstart, svec, hung);
        chk("b2b_hung", hung, 0);
        chk("b2b_result", result, 42);
        chk("b2b_lat", lat, 3);
        @(posedge clk); #1;

        // Unit never answers.
        mute = 3'b100;
        do_op(2, 1, 1, 120, r, e, lat, nstart, svec, hung);
`ifdef ALU_CTRL_TIMEOUT_EN
        chk("tmo_hung", hung, 0);
        chk("tmo_lat", lat, TMO + 1);
        chk("tmo_error", e, 1);
        chk("tmo_result", r, 0);
        chk("tmo_busy", busy, 0);
`else
        chk("notmo_hung", hung, 1);
        chk("notmo_busy", busy, 1);
        chk("notmo_valid", valid, 0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mute = '0;
        chk("tmo_rst_busy", busy, 0);
        @(posedge clk); #1;

        // Reset in the middle of WAIT, followed by a late done from the unit.
        do_op(0, 5, 3, 20, r, e, lat, nstart, svec, hung);
        chk("pre_rst_result", r, 8);
        @(posedge clk); #1;
        nmask = 3'b100;
        go = 1'b1; op = 2'd2; a = 8'sd9; b = 8'sd9;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #1;
        chk("mid_wait_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        noise_man = 3'b100;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", unit_start, 0);
        chk("mid_rst_unit_a", unit_a, 0);
        chk("mid_rst_unit_b", unit_b, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_error", error, 0);
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            noise_man = '0;
            if (valid !== 1'b0) vcount++;
        end
        chk("mid_rst_no_valid", vcount, 0);
        chk("mid_rst_idle", busy, 0);
        chk("mid_rst_result_after", result, 0);

        // Random traffic with spurious done pulses on the other units.
        noise_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            o = $urandom_range(0, 3);
            x = int'($urandom_range(0, 255)) - 128;
            y = int'($urandom_range(0, 255)) - 128;
            do_op(o, x, y, 50, r, e, lat, nstart, svec, hung);
            chk("rnd_hung", hung, 0);
            chk("rnd_result", r, ref_result(o, x, y));
            chk("rnd_error", e, (o >= NU) ? 1 : 0);
            chk("rnd_lat", lat, (o >= NU) ? 0 : int'(dly[o]) + 2);
            chk("rnd_nstart", nstart, (o >= NU) ? 0 : 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        noise_en = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
